// File: rtl/mem_region_router.sv
// Sequential address-region router: buffers core requests in a small FIFO, decodes
// each against NREG [base, top) windows and forwards it to one slave at a time.
module mem_region_router #(
  parameter int                   XLEN       = 32,
  parameter int                   NREG       = 3,
  parameter logic [NREG*XLEN-1:0] BASE_ADDR  = {32'h2000000, 32'h1000000, 32'h0},
  parameter logic [NREG*XLEN-1:0] TOP_ADDR   = {32'h200C000, 32'h1000004, 32'h100000},
  parameter int                   PEND_DEPTH = 4,
  parameter int                   TIMEOUT    = 256
) (
  input  logic                   reset,
  input  logic                   clock,
  input  logic                   m_valid,
  input  logic                   m_instr,
  input  logic [XLEN-1:0]        m_addr,
  input  logic [XLEN-1:0]        m_wdata,
  input  logic [XLEN/8-1:0]      m_wstrb,
  output logic [XLEN-1:0]        m_rdata,
  output logic                   m_ready,
  output logic                   m_error,
  output logic                   m_full,
  output logic                   m_overflow,
  output logic [NREG-1:0]        s_valid,
  output logic                   s_instr,
  output logic [XLEN-1:0]        s_addr,
  output logic [XLEN-1:0]        s_wdata,
  output logic [XLEN/8-1:0]      s_wstrb,
  input  logic [NREG*XLEN-1:0]   s_rdata,
  input  logic [NREG-1:0]        s_ready
);

  localparam int WB = XLEN / 8;
  localparam int PW = $clog2(PEND_DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = (NREG > 1) ? $clog2(NREG) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(PEND_DEPTH);
  localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  state_t state, state_nxt;

  logic            fifo_instr [PEND_DEPTH];
  logic [XLEN-1:0] fifo_addr  [PEND_DEPTH];
  logic [XLEN-1:0] fifo_wdata [PEND_DEPTH];
  logic [WB-1:0]   fifo_wstrb [PEND_DEPTH];

  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_nxt;
  logic [TW-1:0] timer;
  logic [SW-1:0] sel;

  logic            push, pop, issue, ok_rsp, miss_rsp, tmo_rsp;
  logic [XLEN-1:0] head_addr;
  logic            dec_hit;
  logic [SW-1:0]   dec_idx;
  logic [NREG-1:0] dec_oh;
  logic            sel_ready;
  logic [XLEN-1:0] sel_rdata;

  // An empty window (base >= top) can never match.
  function automatic logic region_hit(input int idx, input logic [XLEN-1:0] addr);
    logic [XLEN-1:0] lo, hi;
    lo = BASE_ADDR[idx*XLEN +: XLEN];
    hi = TOP_ADDR[idx*XLEN +: XLEN];
    return (lo < hi) && (addr >= lo) && (addr < hi);
  endfunction

  assign head_addr = fifo_addr[rd_ptr];
  assign push      = m_valid && (count != DEPTH_C);

  // Scan downward so the lowest matching index is the one left standing.
  always_comb begin
    dec_hit = 1'b0;
    dec_idx = '0;
    dec_oh  = '0;
    for (int i = NREG - 1; i >= 0; i--) begin
      if (region_hit(i, head_addr)) begin
        dec_hit = 1'b1;
        dec_idx = SW'(i);
      end
    end
    for (int i = 0; i < NREG; i++) begin
      dec_oh[i] = dec_hit && (dec_idx == SW'(i));
    end
  end

  always_comb begin
    sel_ready = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < NREG; i++) begin
      if (sel == SW'(i)) begin
        sel_ready = s_ready[i];
        sel_rdata = s_rdata[i*XLEN +: XLEN];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    issue     = 1'b0;
    ok_rsp    = 1'b0;
    miss_rsp  = 1'b0;
    tmo_rsp   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (count != '0) begin
          pop = 1'b1;
          if (dec_hit) begin
            issue     = 1'b1;
            state_nxt = ST_WAIT;
          end else begin
            miss_rsp = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        if (sel_ready) begin
          ok_rsp    = 1'b1;
          state_nxt = ST_IDLE;
        end else if ((TIMEOUT != 0) && (timer == TMO_LAST)) begin
          tmo_rsp   = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    case ({push, pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clock) begin
    if (push) begin
      fifo_instr[wr_ptr] <= m_instr;
      fifo_addr[wr_ptr]  <= m_addr;
      fifo_wdata[wr_ptr] <= m_wdata;
      fifo_wstrb[wr_ptr] <= m_wstrb;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= ST_IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      timer      <= '0;
      sel        <= '0;
      m_rdata    <= '0;
      m_ready    <= 1'b0;
      m_error    <= 1'b0;
      m_full     <= 1'b0;
      m_overflow <= 1'b0;
      s_valid    <= '0;
      s_instr    <= 1'b0;
      s_addr     <= '0;
      s_wdata    <= '0;
      s_wstrb    <= '0;
    end else begin
      state  <= state_nxt;
      count  <= count_nxt;
      m_full <= (count_nxt == DEPTH_C);
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      // A drop is judged on the registered count, so a same-cycle pop does not save it.
      if (m_valid && (count == DEPTH_C)) m_overflow <= 1'b1;

      s_valid <= '0;
      if (issue) begin
        s_valid <= dec_oh;
        s_instr <= fifo_instr[rd_ptr];
        s_addr  <= head_addr;
        s_wdata <= fifo_wdata[rd_ptr];
        s_wstrb <= fifo_wstrb[rd_ptr];
        sel     <= dec_idx;
        timer   <= '0;
      end else if ((state == ST_WAIT) && (TIMEOUT != 0)) begin
        timer <= timer + 1'b1;
      end

      m_ready <= ok_rsp | miss_rsp | tmo_rsp;
      m_error <= miss_rsp | tmo_rsp;
      m_rdata <= ok_rsp ? sel_rdata : '0;
    end
  end

endmodule

// File: tb/tb_mem_region_router.sv
// Directed bench for mem_region_router: one default-map instance with a responsive
// slave model, one overlap-map instance with TIMEOUT=8 driven by hand.
module tb_mem_region_router;

  localparam logic [31:0] KEY = 32'hDEADBAEF;

  typedef struct packed {
    logic        err;
    logic [31:0] data;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  exp_t a_q[$];
  exp_t b_q[$];

  logic        a_m_valid, a_m_instr, a_m_ready, a_m_error, a_m_full, a_m_overflow, a_s_instr;
  logic [31:0] a_m_addr, a_m_wdata, a_m_rdata, a_s_addr, a_s_wdata;
  logic [3:0]  a_m_wstrb, a_s_wstrb;
  logic [2:0]  a_s_valid;
  logic [2:0]  a_s_ready = '0;
  logic [95:0] a_s_rdata = '0;

  logic        b_m_valid, b_m_instr, b_m_ready, b_m_error, b_m_full, b_m_overflow, b_s_instr;
  logic [31:0] b_m_addr, b_m_wdata, b_m_rdata, b_s_addr, b_s_wdata;
  logic [3:0]  b_m_wstrb, b_s_wstrb;
  logic [2:0]  b_s_valid, b_s_ready;
  logic [95:0] b_s_rdata;

  mem_region_router dut_a (
    .reset(reset), .clock(clock),
    .m_valid(a_m_valid), .m_instr(a_m_instr), .m_addr(a_m_addr), .m_wdata(a_m_wdata),
    .m_wstrb(a_m_wstrb), .m_rdata(a_m_rdata), .m_ready(a_m_ready), .m_error(a_m_error),
    .m_full(a_m_full), .m_overflow(a_m_overflow), .s_valid(a_s_valid), .s_instr(a_s_instr),
    .s_addr(a_s_addr), .s_wdata(a_s_wdata), .s_wstrb(a_s_wstrb), .s_rdata(a_s_rdata),
    .s_ready(a_s_ready)
  );

  mem_region_router #(
    .BASE_ADDR({32'h2000000, 32'h0, 32'h0}),
    .TOP_ADDR ({32'h200C000, 32'h1000, 32'h1000}),
    .TIMEOUT  (8)
  ) dut_b (
    .reset(reset), .clock(clock),
    .m_valid(b_m_valid), .m_instr(b_m_instr), .m_addr(b_m_addr), .m_wdata(b_m_wdata),
    .m_wstrb(b_m_wstrb), .m_rdata(b_m_rdata), .m_ready(b_m_ready), .m_error(b_m_error),
    .m_full(b_m_full), .m_overflow(b_m_overflow), .s_valid(b_s_valid), .s_instr(b_s_instr),
    .s_addr(b_s_addr), .s_wdata(b_s_wdata), .s_wstrb(b_s_wstrb), .s_rdata(b_s_rdata),
    .s_ready(b_s_ready)
  );

  function automatic logic [31:0] slave_val(input logic [31:0] addr);
    return addr ^ KEY;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic a_expect(input logic err, input logic [31:0] data);
    a_q.push_back({err, data});
  endtask

  task automatic b_expect(input logic err, input logic [31:0] data);
    b_q.push_back({err, data});
  endtask

  task automatic a_send(input logic instr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] wstrb);
    a_m_valid = 1'b1;
    a_m_instr = instr;
    a_m_addr  = addr;
    a_m_wdata = wdata;
    a_m_wstrb = wstrb;
    cyc(1);
    a_m_valid = 1'b0;
  endtask

  task automatic b_send(input logic [31:0] addr);
    b_m_valid = 1'b1;
    b_m_addr  = addr;
    cyc(1);
    b_m_valid = 1'b0;
  endtask

  // Slave model for dut_a: answers sl_wait cycles after seeing s_valid, other slices hold junk.
  int          sl_wait = 0;
  int          sl_cnt  = 0;
  int          sl_idx  = 0;
  logic        sl_busy = 1'b0;
  logic [31:0] sl_addr = '0;

  always @(negedge clock) begin
    a_s_ready = '0;
    if (!sl_busy && (a_s_valid != 3'b000)) begin
      sl_busy = 1'b1;
      sl_cnt  = sl_wait;
      sl_addr = a_s_addr;
      sl_idx  = a_s_valid[2] ? 2 : (a_s_valid[1] ? 1 : 0);
    end
    if (sl_busy) begin
      if (sl_cnt == 0) begin
        sl_busy = 1'b0;
        a_s_ready[sl_idx] = 1'b1;
        a_s_rdata = {3{~slave_val(sl_addr)}};
        a_s_rdata[sl_idx*32 +: 32] = slave_val(sl_addr);
      end else begin
        sl_cnt--;
      end
    end
  end

  always @(negedge clock) begin
    if (reset) begin
      if (a_m_ready === 1'b1) begin
        if (a_q.size() == 0) begin
          chk("a_unexpected_rsp", a_m_ready, 32'd0);
        end else begin
          exp_t e;
          e = a_q.pop_front();
          chk("a_rsp_err", a_m_error, e.err);
          chk("a_rsp_data", a_m_rdata, e.data);
        end
      end else begin
        chk("a_rdata_idle", a_m_rdata, 32'd0);
      end
    end
  end

  always @(negedge clock) begin
    if (reset && (b_m_ready === 1'b1)) begin
      if (b_q.size() == 0) begin
        chk("b_unexpected_rsp", b_m_ready, 32'd0);
      end else begin
        exp_t e;
        e = b_q.pop_front();
        chk("b_rsp_err", b_m_error, e.err);
        chk("b_rsp_data", b_m_rdata, e.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    a_m_valid = 0; a_m_instr = 0; a_m_addr = '0; a_m_wdata = '0; a_m_wstrb = '0;
    b_m_valid = 0; b_m_instr = 0; b_m_addr = '0; b_m_wdata = '0; b_m_wstrb = '0;
    b_s_ready = '0; b_s_rdata = '0;
    reset = 1'b0;
    cyc(3);
    chk("rst_m_ready", a_m_ready, 0);
    chk("rst_m_error", a_m_error, 0);
    chk("rst_m_rdata", a_m_rdata, 0);
    chk("rst_m_full", a_m_full, 0);
    chk("rst_m_overflow", a_m_overflow, 0);
    chk("rst_s_valid", a_s_valid, 0);
    chk("rst_s_addr", a_s_addr, 0);
    chk("rst_s_wdata", a_s_wdata, 0);
    chk("rst_s_wstrb", a_s_wstrb, 0);
    chk("rst_s_instr", a_s_instr, 0);
    chk("rst_b_s_valid", b_s_valid, 0);
    chk("rst_b_m_ready", b_m_ready, 0);
    reset = 1'b1;
    cyc(1);

    sl_wait = 0;
    a_expect(1'b0, 32'hDEADBEEF);
    a_send(1'b1, 32'h400, 32'h0, 4'h0);
    chk("rd_s_valid_c1", a_s_valid, 3'b000);
    cyc(1);
    chk("rd_s_valid_c2", a_s_valid, 3'b001);
    chk("rd_s_addr", a_s_addr, 32'h400);
    chk("rd_s_instr", a_s_instr, 1);
    chk("rd_m_ready_c2", a_m_ready, 0);
    cyc(1);
    chk("rd_m_ready_c3", a_m_ready, 1);
    chk("rd_m_error", a_m_error, 0);
    chk("rd_m_rdata", a_m_rdata, 32'hDEADBEEF);
    chk("rd_s_valid_c3", a_s_valid, 3'b000);
    cyc(1);
    chk("rd_m_ready_c4", a_m_ready, 0);

    a_expect(1'b0, slave_val(32'h1000000));
    a_send(1'b0, 32'h1000000, 32'h41, 4'hF);
    cyc(1);
    chk("pr_s_valid", a_s_valid, 3'b010);
    chk("pr_s_wdata", a_s_wdata, 32'h41);
    chk("pr_s_wstrb", a_s_wstrb, 4'hF);
    chk("pr_s_instr", a_s_instr, 0);
    cyc(1);
    chk("pr_m_ready", a_m_ready, 1);
    cyc(1);

    a_expect(1'b1, 32'h0);
    a_send(1'b0, 32'h1000004, 32'h55, 4'h3);
    chk("miss_m_ready_c1", a_m_ready, 0);
    cyc(1);
    chk("miss_m_ready_c2", a_m_ready, 1);
    chk("miss_m_error", a_m_error, 1);
    chk("miss_m_rdata", a_m_rdata, 0);
    chk("miss_s_valid_c2", a_s_valid, 3'b000);
    chk("miss_s_addr_hold", a_s_addr, 32'h1000000);
    chk("miss_s_wdata_hold", a_s_wdata, 32'h41);
    cyc(1);
    chk("miss_m_ready_c3", a_m_ready, 0);
    chk("miss_s_valid_c3", a_s_valid, 3'b000);
    cyc(1);

    // The first pulse is issued at once, so pulses 2-5 fill the FIFO and the sixth is dropped.
    sl_wait = 10;
    for (int k = 0; k < 6; k++) begin
      if (k == 4) chk("fifo_not_full_c4", a_m_full, 0);
      if (k == 5) begin
        chk("fifo_full_c5", a_m_full, 1);
        chk("fifo_ovf_c5", a_m_overflow, 0);
      end
      a_m_valid = 1'b1;
      a_m_instr = 1'b0;
      a_m_addr  = 32'h100 + 32'(4 * k);
      a_m_wdata = 32'(k);
      a_m_wstrb = 4'h0;
      if (k < 5) a_expect(1'b0, slave_val(32'h100 + 32'(4 * k)));
      cyc(1);
    end
    a_m_valid = 1'b0;
    chk("fifo_ovf_c6", a_m_overflow, 1);
    chk("fifo_full_c6", a_m_full, 1);
    for (int i = 0; i < 200 && a_q.size() != 0; i++) cyc(1);
    cyc(2);
    chk("fifo_drained", a_q.size(), 0);
    chk("fifo_ovf_sticky", a_m_overflow, 1);
    chk("fifo_full_after", a_m_full, 0);
    reset = 1'b0;
    cyc(1);
    chk("ovf_cleared", a_m_overflow, 0);
    reset = 1'b1;
    cyc(1);

    sl_wait = 5;
    a_send(1'b0, 32'h200, 32'h7, 4'h1);
    cyc(1);
    chk("rw_s_valid", a_s_valid, 3'b001);
    cyc(1);
    reset = 1'b0;
    cyc(1);
    chk("rw_m_ready", a_m_ready, 0);
    chk("rw_m_error", a_m_error, 0);
    chk("rw_m_rdata", a_m_rdata, 0);
    chk("rw_s_valid_rst", a_s_valid, 0);
    chk("rw_s_addr", a_s_addr, 0);
    chk("rw_s_wdata", a_s_wdata, 0);
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cyc(1);
      chk("rw_late_ready", a_m_ready, 0);
    end

    b_expect(1'b0, 32'h12345678);
    b_send(32'h10);
    cyc(1);
    chk("ovl_s_valid", b_s_valid, 3'b001);
    b_s_rdata = {32'h0, 32'hFFFFFFFF, 32'h12345678};
    b_s_ready = 3'b001;
    cyc(1);
    b_s_ready = 3'b000;
    chk("ovl_m_ready", b_m_ready, 1);
    chk("ovl_m_rdata", b_m_rdata, 32'h12345678);

    b_expect(1'b1, 32'h0);
    b_send(32'h1000);
    cyc(1);
    chk("top_excl_m_ready", b_m_ready, 1);
    chk("top_excl_m_error", b_m_error, 1);
    chk("top_excl_s_valid", b_s_valid, 3'b000);
    cyc(1);

    b_expect(1'b1, 32'h0);
    b_send(32'h2000000);
    cyc(1);
    chk("tmo_s_valid", b_s_valid, 3'b100);
    for (int t = 3; t <= 9; t++) begin
      cyc(1);
      b_s_ready = (t == 4) ? 3'b011 : 3'b000;
      b_s_rdata = {3{32'hBAD0BAD0}};
      chk("tmo_quiet", b_m_ready, 0);
    end
    cyc(1);
    chk("tmo_m_ready", b_m_ready, 1);
    chk("tmo_m_error", b_m_error, 1);
    chk("tmo_m_rdata", b_m_rdata, 0);
    b_s_ready = 3'b100;
    cyc(1);
    b_s_ready = 3'b000;
    chk("tmo_late_c11", b_m_ready, 0);
    cyc(2);
    chk("tmo_late_c13", b_m_ready, 0);

    b_expect(1'b0, 32'hCAFE0002);
    b_send(32'h2000010);
    cyc(1);
    chk("prec_s_valid", b_s_valid, 3'b100);
    cyc(7);
    b_s_rdata = {32'hCAFE0002, 32'h0, 32'h0};
    b_s_ready = 3'b100;
    chk("prec_m_ready_c9", b_m_ready, 0);
    cyc(1);
    b_s_ready = 3'b000;
    chk("prec_m_ready", b_m_ready, 1);
    chk("prec_m_error", b_m_error, 0);
    chk("prec_m_rdata", b_m_rdata, 32'hCAFE0002);
    cyc(3);

    chk("a_queue_empty", a_q.size(), 0);
    chk("b_queue_empty", b_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
